// File: rtl/hf_decoder_param_if.sv
// Signal bundle for hf_decoder_param: code-table write port, serial bit input
// and decoded symbol output. The decoder is the slave; the source/consumer side
// is the master.
interface hf_decoder_param_if #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 16
);
  localparam int NUM_SYM = 1 << SYM_W;
  localparam int IDX_W   = $clog2(NUM_SYM);
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  // Table load / control
  logic               tbl_wr;
  logic [IDX_W-1:0]   tbl_idx;
  logic [MAX_LEN-1:0] tbl_code;
  logic [LEN_W-1:0]   tbl_len;
  logic [SYM_W-1:0]   tbl_sym;
  logic               tbl_done;
  logic               tbl_clear;
  logic               err_clr;

  // Compressed bit input
  logic               hf_in;
  logic               hf_in_valid;
  logic               hf_in_ready;

  // Decoded symbol output
  logic [SYM_W-1:0]   hf_out;
  logic               hf_out_valid;
  logic               hf_out_ready;
  logic               hf_err;

  modport master (
    output tbl_wr, tbl_idx, tbl_code, tbl_len, tbl_sym, tbl_done, tbl_clear, err_clr,
    output hf_in, hf_in_valid, hf_out_ready,
    input  hf_in_ready, hf_out, hf_out_valid, hf_err
  );

  modport slave (
    input  tbl_wr, tbl_idx, tbl_code, tbl_len, tbl_sym, tbl_done, tbl_clear, err_clr,
    input  hf_in, hf_in_valid, hf_out_ready,
    output hf_in_ready, hf_out, hf_out_valid, hf_err
  );
endinterface

// File: rtl/hf_decoder_param.sv
// Parametrised serial Huffman decoder. A code table is written in LOAD, then
// bits arriving MSB-first are matched against it in DECODE; an unmatched code
// reaching MAX_LEN bits parks the block in ERROR until err_clr or tbl_clear.
// Optional feature macro: HF_DECODER_STATS_EN adds saturating sym_count and
// err_count statistics outputs.
module hf_decoder_param #(
  parameter int SYM_W   = 4,
  parameter int NUM_SYM = 1 << SYM_W,
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = $clog2(NUM_SYM),
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic CLK,
  input  logic Reset,
`ifdef HF_DECODER_STATS_EN
  output logic [31:0] sym_count,
  output logic [15:0] err_count,
`endif
  hf_decoder_param_if.slave bus
);

  typedef enum logic [1:0] {ST_LOAD, ST_DECODE, ST_ERROR} state_t;

  state_t             state_q;
  logic [NUM_SYM-1:0] ent_vld_q;
  logic [MAX_LEN-1:0] ent_code_q [NUM_SYM];
  logic [LEN_W-1:0]   ent_len_q  [NUM_SYM];
  logic [SYM_W-1:0]   ent_sym_q  [NUM_SYM];
  logic [MAX_LEN-2:0] shift_q;
  logic [LEN_W-1:0]   count_q;
  logic [SYM_W-1:0]   out_q;
  logic               out_vld_q;
  logic               err_q;

  logic               in_rdy;
  logic               bit_acc;
  logic               out_hs;
  logic               tbl_we;
  logic               overflow;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   n_bits;
  logic               hit;
  logic [SYM_W-1:0]   hit_sym;

  assign in_rdy   = (state_q == ST_DECODE) && (!out_vld_q || bus.hf_out_ready);
  assign bit_acc  = in_rdy && bus.hf_in_valid;
  assign out_hs   = out_vld_q && bus.hf_out_ready;
  assign tbl_we   = (state_q == ST_LOAD) && bus.tbl_wr && !bus.tbl_clear;
  assign cand     = {shift_q, bus.hf_in};
  assign n_bits   = count_q + LEN_W'(1);
  assign len_mask = ~({MAX_LEN{1'b1}} << n_bits);
  assign overflow = bit_acc && !hit && (n_bits == LEN_W'(MAX_LEN));

  // Table lookup at the exact candidate length; scanning downward lets the
  // lowest matching index win.
  always_comb begin
    // NOTE: defaults first so every path assigns hit/hit_sym and no latch is inferred.
    hit     = 1'b0;
    hit_sym = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (ent_vld_q[i] && (ent_len_q[i] == n_bits) &&
          (((ent_code_q[i] ^ cand) & len_mask) == '0)) begin
        hit     = 1'b1;
        hit_sym = ent_sym_q[i];
      end
    end
  end

  // Table payload storage; only the valid bits need a reset value.
  // NOTE: code/len/sym arrays are deliberately not reset -- ent_vld_q gates them,
  // and leaving them reset-free lets them map onto plain RAM/flops without reset fan-out.
  always_ff @(posedge CLK) begin
    if (tbl_we) begin
      ent_code_q[bus.tbl_idx] <= bus.tbl_code;
      ent_len_q[bus.tbl_idx]  <= bus.tbl_len;
      ent_sym_q[bus.tbl_idx]  <= bus.tbl_sym;
    end
  end

  // Control FSM with registered outputs; tbl_clear overrides every state.
  always_ff @(posedge CLK or negedge Reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!Reset) begin
      state_q   <= ST_LOAD;
      ent_vld_q <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (bus.tbl_clear) begin
      state_q   <= ST_LOAD;
      ent_vld_q <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (out_hs) out_vld_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (tbl_we) ent_vld_q[bus.tbl_idx] <= (bus.tbl_len != '0);
          if (bus.tbl_done) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          if (bit_acc) begin
            if (hit) begin
              out_q     <= hit_sym;
              out_vld_q <= 1'b1;
              shift_q   <= '0;
              count_q   <= '0;
            end else if (overflow) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
              shift_q <= '0;
              count_q <= '0;
            end else begin
              shift_q <= cand[MAX_LEN-2:0];
              count_q <= n_bits;
            end
          end
        end
        ST_ERROR: begin
          if (bus.err_clr) begin
            state_q <= ST_DECODE;
            err_q   <= 1'b0;
            shift_q <= '0;
            count_q <= '0;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.hf_in_ready  = in_rdy;
  assign bus.hf_out       = out_q;
  assign bus.hf_out_valid = out_vld_q;
  assign bus.hf_err       = err_q;

`ifdef HF_DECODER_STATS_EN
  // Saturating symbol-handshake and error-entry counters.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sym_count <= '0;
      err_count <= '0;
    end else if (bus.tbl_clear) begin
      sym_count <= '0;
      err_count <= '0;
    end else begin
      if (out_hs && (sym_count != '1)) sym_count <= sym_count + 32'd1;
      if ((state_q == ST_DECODE) && overflow && (err_count != '1)) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hf_decoder_param.sv
// Testbench for hf_decoder_param: table-driven directed vectors, hand-written
// corner sequences and a randomized run against a bit-queue reference model.
module tb_hf_decoder_param;
  localparam int SYM_W   = 4;
  localparam int MAX_LEN = 4;
  localparam int NUM_SYM = 1 << SYM_W;

  logic CLK   = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  hf_decoder_param_if #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN)) bus ();

`ifdef HF_DECODER_STATS_EN
  logic [31:0] sym_count;
  logic [15:0] err_count;
`endif

  hf_decoder_param #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN)) dut (
    .CLK   (CLK),
    .Reset (Reset),
`ifdef HF_DECODER_STATS_EN
    .sym_count (sym_count),
    .err_count (err_count),
`endif
    .bus   (bus)
  );

  typedef struct packed {
    logic       in_bit;
    logic       in_vld;
    logic       out_rdy;
    logic       e_rdy;
    logic       e_vld;
    logic [3:0] e_out;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Reference model state
  int   t_code [NUM_SYM];
  int   t_len  [NUM_SYM];
  int   t_sym  [NUM_SYM];
  bit   m_bits[$];
  logic m_pend;
  logic m_err;
  int   m_sym;
  int   res;
  logic exp_rdy;
  logic prev_vld;
  int   exp_syms;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.tbl_wr = 0; bus.tbl_idx = '0; bus.tbl_code = '0; bus.tbl_len = '0; bus.tbl_sym = '0;
    bus.tbl_done = 0; bus.tbl_clear = 0; bus.err_clr = 0;
    bus.hf_in = 0; bus.hf_in_valid = 0; bus.hf_out_ready = 1;
  endtask

  task automatic load(input int idx, input int code, input int len, input int sym);
    bus.tbl_wr = 1; bus.tbl_idx = 4'(idx); bus.tbl_code = 4'(code);
    bus.tbl_len = 3'(len); bus.tbl_sym = 4'(sym);
    cyc();
    bus.tbl_wr = 0;
  endtask

  task automatic done();
    bus.tbl_done = 1; cyc(); bus.tbl_done = 0;
  endtask

  task automatic clear();
    bus.tbl_clear = 1; cyc(); bus.tbl_clear = 0;
  endtask

  task automatic load_t1();
    load(0, 'b0, 1, 'h3);
    load(1, 'b10, 2, 'h5);
    load(2, 'b11, 2, 'hA);
  endtask

  // Offer one bit, wait (bounded) for acceptance, return just after the edge.
  task automatic send_bit(input logic b, input string name);
    int k = 0;
    bus.hf_in = b; bus.hf_in_valid = 1;
    #1;
    while (!bus.hf_in_ready && k < 20) begin cyc(); k++; end
    check({name, "_accept"}, 32'(bus.hf_in_ready), 1);
    @(posedge CLK); #1;
    bus.hf_in_valid = 0;
  endtask

  task automatic add_vec(input logic b, input logic v, input logic r,
                         input logic er, input logic ev, input logic [3:0] eo);
    vec_t x;
    x = '{in_bit: b, in_vld: v, out_rdy: r, e_rdy: er, e_vld: ev, e_out: eo};
    vecs.push_back(x);
  endtask

  // Accumulates bits MSB-first; returns symbol, -1 (need more bits) or -2 (overlong).
  function automatic int model_bit(input bit b);
    int val = 0;
    int n;
    m_bits.push_back(b);
    n = m_bits.size();
    foreach (m_bits[k]) val = val * 2 + int'(m_bits[k]);
    for (int i = 0; i < NUM_SYM; i++) begin
      if (t_len[i] == n && (t_code[i] % (1 << n)) == val) begin
        m_bits.delete();
        return t_sym[i];
      end
    end
    if (n == MAX_LEN) begin
      m_bits.delete();
      return -2;
    end
    return -1;
  endfunction

  initial begin
    idle();
    // ---- Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out", 32'(bus.hf_out), 0);
    check("rst_vld", 32'(bus.hf_out_valid), 0);
    check("rst_err", 32'(bus.hf_err), 0);
    check("rst_rdy", 32'(bus.hf_in_ready), 0);
    Reset = 1;
    cyc();
    check("load_rdy", 32'(bus.hf_in_ready), 0);

    // ---- T1 basic + back-to-back 1-bit codes, then T2 backpressure
    add_vec(0,1,1, 1,1,4'h3); add_vec(1,1,1, 1,0,4'h3); add_vec(0,1,1, 1,1,4'h5);
    add_vec(1,1,1, 1,0,4'h5); add_vec(1,1,1, 1,1,4'hA); add_vec(0,0,1, 1,0,4'hA);
    add_vec(0,1,1, 1,1,4'h3); add_vec(0,1,1, 1,1,4'h3); add_vec(0,0,1, 1,0,4'h3);
    add_vec(0,1,1, 1,1,4'h3); add_vec(1,1,0, 0,1,4'h3); add_vec(1,1,0, 0,1,4'h3);
    add_vec(1,1,1, 1,0,4'h3); add_vec(0,1,1, 1,1,4'h5); add_vec(1,1,0, 0,1,4'h5);
    add_vec(1,1,1, 1,0,4'h5); add_vec(1,1,1, 1,1,4'hA); add_vec(0,0,0, 0,1,4'hA);
    add_vec(0,0,1, 1,0,4'hA);
    load_t1();
    done();
    prev_vld = 0; exp_syms = 0;
    foreach (vecs[i]) begin
      bus.hf_in = vecs[i].in_bit; bus.hf_in_valid = vecs[i].in_vld; bus.hf_out_ready = vecs[i].out_rdy;
      #1;
      check($sformatf("vec%0d_rdy", i), 32'(bus.hf_in_ready), 32'(vecs[i].e_rdy));
      if (prev_vld && vecs[i].out_rdy) exp_syms++;
      prev_vld = vecs[i].e_vld;
      cyc();
      check($sformatf("vec%0d_vld", i), 32'(bus.hf_out_valid), 32'(vecs[i].e_vld));
      check($sformatf("vec%0d_out", i), 32'(bus.hf_out), 32'(vecs[i].e_out));
      check($sformatf("vec%0d_err", i), 32'(bus.hf_err), 0);
    end
    idle();
`ifdef HF_DECODER_STATS_EN
    check("stat_vec_sym", sym_count, 32'(exp_syms));
    check("stat_vec_err", 32'(err_count), 0);
`endif

    // ---- Table writes ignored in DECODE
    load(0, 'b0, 1, 'h9);
    send_bit(0, "wr_ign");
    check("wr_ign_vld", 32'(bus.hf_out_valid), 1);
    check("wr_ign_out", 32'(bus.hf_out), 'h3);
    cyc();

    // ---- T3 error path
    clear();
`ifdef HF_DECODER_STATS_EN
    check("stat_clr_sym", sym_count, 0);
    check("stat_clr_err", 32'(err_count), 0);
`endif
    load(0, 'b0, 1, 'h7);
    done();
    send_bit(1, "t3_b0"); send_bit(1, "t3_b1"); send_bit(1, "t3_b2");
    check("t3_err_early", 32'(bus.hf_err), 0);
    send_bit(1, "t3_b3");
    check("t3_err", 32'(bus.hf_err), 1);
    bus.hf_in_valid = 1;
    #1;
    check("t3_err_rdy", 32'(bus.hf_in_ready), 0);
    cyc();
    check("t3_err_hold", 32'(bus.hf_err), 1);
    check("t3_err_vld", 32'(bus.hf_out_valid), 0);
    bus.hf_in_valid = 0; bus.err_clr = 1;
    cyc();
    bus.err_clr = 0;
    check("t3_err_clr", 32'(bus.hf_err), 0);
    send_bit(0, "t3_after");
    check("t3_vld", 32'(bus.hf_out_valid), 1);
    check("t3_out", 32'(bus.hf_out), 'h7);
    cyc();
`ifdef HF_DECODER_STATS_EN
    check("stat_t3_sym", sym_count, 1);
    check("stat_t3_err", 32'(err_count), 1);
`endif

    // ---- T4 full-length 4-bit codes
    clear();
    for (int i = 0; i < NUM_SYM; i++) load(i, i, 4, 15 - i);
    done();
    for (int i = 0; i < NUM_SYM; i++) begin
      for (int b = 3; b >= 0; b--) send_bit(1'((i >> b) & 1), "t4");
      check($sformatf("t4_vld%0d", i), 32'(bus.hf_out_valid), 1);
      check($sformatf("t4_out%0d", i), 32'(bus.hf_out), 32'(15 - i));
    end
    cyc();

    // ---- T5 reset mid-code
    clear(); load_t1(); done();
    send_bit(1, "t5r");
    Reset = 0;
    #1;
    check("t5r_out", 32'(bus.hf_out), 0);
    check("t5r_vld", 32'(bus.hf_out_valid), 0);
    check("t5r_err", 32'(bus.hf_err), 0);
    check("t5r_rdy", 32'(bus.hf_in_ready), 0);
    cyc();
    Reset = 1;
    bus.hf_in = 0; bus.hf_in_valid = 1;
    #1;
    check("t5r_load_rdy", 32'(bus.hf_in_ready), 0);
    cyc();
    check("t5r_load_vld", 32'(bus.hf_out_valid), 0);
    bus.hf_in_valid = 0;
    done();
    send_bit(0, "t5r_empty");
    check("t5r_tbl_invalid", 32'(bus.hf_out_valid), 0);

    // ---- T5 tbl_clear mid-decode; clear beats tbl_wr and tbl_done
    clear(); load_t1(); done();
    bus.hf_out_ready = 0;
    send_bit(0, "t5c");
    check("t5c_pend", 32'(bus.hf_out_valid), 1);
    bus.tbl_clear = 1; bus.tbl_done = 1; bus.tbl_wr = 1;
    bus.tbl_idx = 4'd0; bus.tbl_code = 4'd0; bus.tbl_len = 3'd1; bus.tbl_sym = 4'h3;
    cyc();
    idle();
    check("t5c_vld", 32'(bus.hf_out_valid), 0);
    check("t5c_err", 32'(bus.hf_err), 0);
    bus.hf_in_valid = 1;
    #1;
    check("t5c_rdy", 32'(bus.hf_in_ready), 0);
    bus.hf_in_valid = 0;
    done();
    send_bit(0, "t5c_b0");
    check("t5c_nowrite", 32'(bus.hf_out_valid), 0);
    send_bit(0, "t5c_b1"); send_bit(0, "t5c_b2"); send_bit(0, "t5c_b3");
    check("t5c_err_end", 32'(bus.hf_err), 1);

    // ---- Randomized run vs. reference model
    for (int r = 0; r < 4; r++) begin
      clear();
      for (int i = 0; i < NUM_SYM; i++) begin
        t_len[i]  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, MAX_LEN));
        t_code[i] = int'($urandom_range(0, (1 << MAX_LEN) - 1));
        t_sym[i]  = int'($urandom_range(0, NUM_SYM - 1));
      end
      if (r == 0) begin
        t_len[3] = 2; t_len[9] = 2; t_code[9] = t_code[3];
      end
      for (int i = 0; i < NUM_SYM; i++) load(i, t_code[i], t_len[i], t_sym[i]);
      done();
      m_bits.delete(); m_pend = 0; m_err = 0; m_sym = 0;
      for (int c = 0; c < 250; c++) begin
        bus.hf_in        = 1'($urandom_range(0, 1));
        bus.hf_in_valid  = ($urandom_range(0, 3) != 0);
        bus.hf_out_ready = ($urandom_range(0, 3) != 0);
        bus.err_clr      = m_err && ($urandom_range(0, 1) == 1);
        #1;
        exp_rdy = !m_err && (!m_pend || bus.hf_out_ready);
        check("rnd_rdy", 32'(bus.hf_in_ready), 32'(exp_rdy));
        if (m_pend && bus.hf_out_ready) m_pend = 0;
        if (m_err) begin
          if (bus.err_clr) m_err = 0;
        end else if (bus.hf_in_valid && exp_rdy) begin
          res = model_bit(bus.hf_in);
          if (res >= 0) begin
            m_pend = 1; m_sym = res;
          end else if (res == -2) begin
            m_err = 1;
          end
        end
        cyc();
        check("rnd_vld", 32'(bus.hf_out_valid), 32'(m_pend));
        if (m_pend) check("rnd_out", 32'(bus.hf_out), 32'(m_sym));
        check("rnd_err", 32'(bus.hf_err), 32'(m_err));
      end
      idle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
